// File: rtl/irq_controller_8.sv
// irq_controller_8 -- 8-line priority interrupt controller.
//
// Raw request lines are synchronised, turned into pending bits (edge or level
// detection), filtered by a per-line mask and presented one at a time on a
// registered valid/id handshake. Once a request is presented it is held until it
// is acknowledged or until the controller is disabled. After every acknowledge
// there is at least one idle cycle before the next request is presented.
//
// Ports:
//   clk        input   1  clock, rising edge
//   rst        input   1  asynchronous active-high reset
//   en         input   1  controller enable
//   irq_in     input   8  raw request lines, bit 7 highest priority
//   mask       input   8  1 = line excluded from selection
//   ack        input   1  acknowledge of the presented irq_id
//   irq_valid  output  1  a request is presented on irq_id
//   irq_id     output  3  presented line index, 0 when irq_valid = 0
//   pending    output  8  pending-request vector
module irq_controller_8 #(
   parameter int unsigned EDGE_MODE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] irq_in,
   input  logic [7:0] mask,
   input  logic       ack,
   output logic       irq_valid,
   output logic [2:0] irq_id,
   output logic [7:0] pending
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      GAP     = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] s1_q, s2_q, s3_q;
   logic [7:0] pend_q, pend_d;
   logic       valid_q, valid_d;
   logic [2:0] id_q, id_d;

   logic [7:0] rise;
   logic [7:0] set_vec;
   logic [7:0] cand;
   logic [2:0] sel;
   logic       ack_take;

   // Synchroniser plus delay flop for edge detection. Resetting them to zero
   // makes a line that is already high at reset release look like a new edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
         s3_q <= '0;
      end else begin
         s1_q <= irq_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise    = s2_q & ~s3_q;
   assign set_vec = en ? ((EDGE_MODE != 0) ? rise : s2_q) : '0;
   assign cand    = pend_q & ~mask;

   // Highest set bit of cand; later iterations override earlier ones.
   always_comb begin
      sel = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (cand[i]) sel = 3'(i);
      end
   end

   // Disable takes priority over an acknowledge in the same cycle: the
   // presentation is withdrawn and the pending bit is kept.
   assign ack_take = (state_q == PRESENT) && en && ack;

   // Clear is applied first so that a simultaneous set wins.
   always_comb begin
      pend_d = pend_q;
      if (ack_take) pend_d[id_q] = 1'b0;
      pend_d = pend_d | set_vec;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) pend_q <= '0;
      else     pend_q <= pend_d;
   end

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (en && (cand != '0)) state_d = PRESENT;
         end
         PRESENT: begin
            if (!en)     state_d = IDLE;
            else if (ack) state_d = GAP;
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM: outputs (next value of the registered valid/id pair)
   always_comb begin
      valid_d = 1'b0;
      id_d    = '0;
      case (state_q)
         IDLE: begin
            if (en && (cand != '0)) begin
               valid_d = 1'b1;
               id_d    = sel;
            end
         end
         PRESENT: begin
            if (en && !ack) begin
               valid_d = valid_q;
               id_d    = id_q;
            end
         end
         default: begin
            valid_d = 1'b0;
            id_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         id_q    <= '0;
      end else begin
         valid_q <= valid_d;
         id_q    <= id_d;
      end
   end

   assign irq_valid = valid_q;
   assign irq_id    = id_q;
   assign pending   = pend_q;

endmodule
